// File: rtl/alu_result_stage_pkg.sv
// Shared ALU result-stage definitions: op-code encodings, skid-buffer state encoding
// and the flag-update predicate used by the ALU, decoder and result stage.
package alu_result_stage_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_RSR  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Only arithmetic and bitwise logic ops define the zero flag; shifts, pass and 111 do not.
    function automatic logic opUpdatesFlag(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu_skid_buffer2.sv
// Two-entry in-order skid buffer; ready/valid are registered so out_ready never
// reaches in_ready combinationally.
module alu_skid_buffer2
    import alu_result_stage_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    skid_state_e   state_q;
    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic          inReady_q;
    logic          outValid_q;
    logic          push;
    logic          pop;

    assign push = in_valid_i && inReady_q;
    assign pop  = outValid_q && out_ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_q     <= in_data_i;
                        state_q    <= ST_ONE;
                        outValid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        tail_q    <= in_data_i;
                        state_q   <= ST_FULL;
                        inReady_q <= 1'b0;
                    end else if (!push && pop) begin
                        state_q    <= ST_EMPTY;
                        outValid_q <= 1'b0;
                    end else if (push && pop) begin
                        head_q <= in_data_i;
                    end
                end
                ST_FULL: begin
                    // The older entry leaves, the younger one moves up to the head.
                    if (pop) begin
                        head_q    <= tail_q;
                        state_q   <= ST_ONE;
                        inReady_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = inReady_q;
    assign out_valid_o = outValid_q;
    assign out_data_o  = outValid_q ? head_q : '0;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: skid-buffers ALU results toward writeback and keeps the zero flag.
// Optional macro ALU_RESULT_STATS_EN adds saturating transfer/stall counters.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int RD_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [WIDTH-1:0]    in_result,
    input  logic                in_is_zero,
    input  logic [RD_WIDTH-1:0] in_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_op,
    output logic [WIDTH-1:0]    out_result,
    output logic [RD_WIDTH-1:0] out_rd,
    output logic                flag_zero
`ifdef ALU_RESULT_STATS_EN
    ,
    output logic [15:0]         stat_results,
    output logic [15:0]         stat_stalls
`endif
);

    localparam int PW = 3 + 1 + RD_WIDTH + WIDTH;

    logic [PW-1:0] inPayload;
    logic [PW-1:0] outPayload;
    logic          headZero;
    logic          pop;
    logic          flagZero_q;

    assign inPayload = {in_op, in_is_zero, in_rd, in_result};

    alu_skid_buffer2 #(.DW(PW)) uBuffer (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (inPayload),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (outPayload)
    );

    assign {out_op, headZero, out_rd, out_result} = outPayload;
    assign pop = out_valid && out_ready;

    // The flag follows the head entry only at the moment it is handed to writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flagZero_q <= 1'b0;
        end else if (pop && opUpdatesFlag(out_op)) begin
            flagZero_q <= headZero;
        end
    end

    assign flag_zero = flagZero_q;

`ifdef ALU_RESULT_STATS_EN
    logic [15:0] statResults_q;
    logic [15:0] statStalls_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statResults_q <= '0;
            statStalls_q  <= '0;
        end else begin
            if (pop && (statResults_q != 16'hFFFF)) begin
                statResults_q <= statResults_q + 16'd1;
            end
            if (out_valid && !out_ready && (statStalls_q != 16'hFFFF)) begin
                statStalls_q <= statStalls_q + 16'd1;
            end
        end
    end

    assign stat_results = statResults_q;
    assign stat_stalls  = statStalls_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a random scoreboard run.
// Counter checks are compiled in when ALU_RESULT_STATS_EN is defined.
module tb_alu_result_stage;

    typedef struct packed {
        logic        v;
        logic [2:0]  op;
        logic        z;
        logic [3:0]  rd;
        logic [31:0] res;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_result;
    logic        in_is_zero;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        flag_zero;
`ifdef ALU_RESULT_STATS_EN
    logic [15:0] stat_results;
    logic [15:0] stat_stalls;
`endif

    int   checks = 0;
    int   fails  = 0;
    ent_t expq[$];
    ent_t popExp;
    ent_t obs;
    bit   lastPop;
    logic flagExp = 1'b0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(32), .RD_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_result  (in_result),
        .in_is_zero (in_is_zero),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .out_rd     (out_rd),
        .flag_zero  (flag_zero)
`ifdef ALU_RESULT_STATS_EN
        ,
        .stat_results (stat_results),
        .stat_stalls  (stat_stalls)
`endif
    );

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                         input logic z, input logic [3:0] rd);
        in_valid   = v;
        in_op      = op;
        in_result  = res;
        in_is_zero = z;
        in_rd      = rd;
    endtask

    // Called at a falling edge: records what will transfer on the next rising edge.
    task automatic tick();
        bit push;
        bit pop;
        push    = in_valid && in_ready && !reset;
        pop     = out_valid && out_ready && !reset;
        lastPop = pop;
        if (pop) begin
            obs = '{v: 1'b1, op: out_op, z: 1'b0, rd: out_rd, res: out_result};
            if (expq.size() > 0) popExp = expq.pop_front();
            else popExp = '0;
            if (popExp.v && (popExp.op inside {3'b000, 3'b001, 3'b101, 3'b110}))
                flagExp = popExp.z;
        end
        if (push) expq.push_back('{v: 1'b1, op: in_op, z: in_is_zero, rd: in_rd, res: in_result});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++;
        if ({out_op, out_rd, out_result} !== '0) begin fails++; $display("[TB] FAIL reset_out_data: got op %0d rd %0d res %0d expected 0", out_op, out_rd, out_result); end
        checks++;
        if (flag_zero !== 1'b0) begin fails++; $display("[TB] FAIL reset_flag: got %0b expected 0", flag_zero); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'd2649, 1'b0, 4'd3);
        tick();
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd2649 || out_rd !== 4'd3) begin
            fails++; $display("[TB] FAIL add_latency: got v %0b res %0d rd %0d expected v 1 res 2649 rd 3", out_valid, out_result, out_rd);
        end
        tick();
        checks++;
        if (!lastPop || {obs.v, obs.op, obs.rd, obs.res} !== {popExp.v, popExp.op, popExp.rd, popExp.res}) begin
            fails++; $display("[TB] FAIL add_pop: got res %0d rd %0d expected res %0d rd %0d", obs.res, obs.rd, popExp.res, popExp.rd);
        end
        checks++;
        if (flag_zero !== 1'b0) begin fails++; $display("[TB] FAIL add_flag: got %0b expected 0", flag_zero); end
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'd0) begin
            fails++; $display("[TB] FAIL add_idle_zero: got v %0b res %0d expected v 0 res 0", out_valid, out_result);
        end
    endtask

    task automatic test_flag();
        logic [2:0]  ops[9]   = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b101, 3'b100, 3'b110, 3'b000};
        logic [31:0] ress[9]  = '{32'd0, 32'd10144, 32'd7, 32'd0, 32'd0, 32'd8, 32'd0, 32'd0, 32'd55};
        logic        zs[9]    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        flags[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i], ress[i], zs[i], 4'(i));
            tick();
            drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
            tick();
            checks++;
            if (!lastPop || {obs.v, obs.op, obs.rd, obs.res} !== {popExp.v, popExp.op, popExp.rd, popExp.res}) begin
                fails++; $display("[TB] FAIL flag_pop_%0d: got op %0d res %0d expected op %0d res %0d", i, obs.op, obs.res, popExp.op, popExp.res);
            end
            checks++;
            if (flag_zero !== flags[i]) begin
                fails++; $display("[TB] FAIL flag_value_%0d: got %0b expected %0b", i, flag_zero, flags[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'b101, 32'd96, 1'b0, 4'd1);
        tick();
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_ready_one: got %0b expected 1", in_ready); end
        drive(1'b1, 3'b110, 32'd3561, 1'b1, 4'd2);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_result !== 32'd96) begin
            fails++; $display("[TB] FAIL bp_full: got ready %0b res %0d expected ready 0 res 96", in_ready, out_result);
        end
        drive(1'b1, 3'b000, 32'd777, 1'b0, 4'd9);
        tick();
        checks++;
        if (out_result !== 32'd96 || out_op !== 3'b101 || out_rd !== 4'd1 || in_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL bp_hold: got res %0d op %0d rd %0d ready %0b expected res 96 op 5 rd 1 ready 0", out_result, out_op, out_rd, in_ready);
        end
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        out_ready = 1'b1;
        tick();
        checks++;
        if (!lastPop || obs.res !== 32'd96 || obs !== {popExp.v, popExp.op, 1'b0, popExp.rd, popExp.res}) begin
            fails++; $display("[TB] FAIL bp_pop1: got res %0d expected 96", obs.res);
        end
        checks++;
        if (in_ready !== 1'b1 || out_result !== 32'd3561) begin
            fails++; $display("[TB] FAIL bp_after_pop1: got ready %0b res %0d expected ready 1 res 3561", in_ready, out_result);
        end
        tick();
        checks++;
        if (!lastPop || obs.res !== 32'd3561 || expq.size() != 0) begin
            fails++; $display("[TB] FAIL bp_pop2: got res %0d pending %0d expected res 3561 pending 0", obs.res, expq.size());
        end
        checks++;
        if (out_valid !== 1'b0 || flag_zero !== 1'b1) begin
            fails++; $display("[TB] FAIL bp_end: got v %0b flag %0b expected v 0 flag 1", out_valid, flag_zero);
        end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'd5, 1'b0, 4'd1);
        tick();
        drive(1'b1, 3'b011, 32'd158, 1'b0, 4'd6);
        tick();
        checks++;
        if (!lastPop || obs.res !== 32'd5) begin fails++; $display("[TB] FAIL pp_pop_old: got res %0d expected 5", obs.res); end
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd158 || out_rd !== 4'd6 || in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL pp_stay_one: got v %0b res %0d rd %0d ready %0b expected v 1 res 158 rd 6 ready 1", out_valid, out_result, out_rd, in_ready);
        end
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        tick();
        checks++;
        if (!lastPop || obs.res !== 32'd158 || out_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL pp_pop_new: got res %0d v %0b expected res 158 v 0", obs.res, out_valid);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 32'd0, 1'b1, 4'd2);
        tick();
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        tick();
        checks++;
        if (flag_zero !== 1'b1) begin fails++; $display("[TB] FAIL rf_flag_set: got %0b expected 1", flag_zero); end
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'd11, 1'b0, 4'd4);
        tick();
        drive(1'b1, 3'b000, 32'd12, 1'b0, 4'd5);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL rf_full: got ready %0b v %0b expected ready 0 v 1", in_ready, out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || flag_zero !== 1'b0 || out_result !== 32'd0) begin
            fails++; $display("[TB] FAIL rf_async: got v %0b flag %0b res %0d expected v 0 flag 0 res 0", out_valid, flag_zero, out_result);
        end
        expq.delete();
        flagExp = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rf_no_transfer: got v %0b expected 0", out_valid); end
        reset = 1'b0;
        drive(1'b1, 3'b000, 32'd42, 1'b0, 4'd7);
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rf_ready_release: got %0b expected 1", in_ready); end
        tick();
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        tick();
        checks++;
        if (!lastPop || obs.res !== 32'd42 || expq.size() != 0) begin
            fails++; $display("[TB] FAIL rf_resume: got res %0d pending %0d expected res 42 pending 0", obs.res, expq.size());
        end
    endtask

    task automatic test_random();
        int badPops = 0;
        int badFlags = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (lastPop) begin
                checks++;
                if ({obs.v, obs.op, obs.rd, obs.res} !== {popExp.v, popExp.op, popExp.rd, popExp.res}) begin
                    fails++; badPops++;
                    if (badPops < 5) $display("[TB] FAIL rand_pop_%0d: got op %0d rd %0d res %0h expected op %0d rd %0d res %0h", i, obs.op, obs.rd, obs.res, popExp.op, popExp.rd, popExp.res);
                end
            end
            checks++;
            if (flag_zero !== flagExp) begin
                fails++; badFlags++;
                if (badFlags < 5) $display("[TB] FAIL rand_flag_%0d: got %0b expected %0b", i, flag_zero, flagExp);
            end
        end
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lastPop) begin
                checks++;
                if ({obs.v, obs.op, obs.rd, obs.res} !== {popExp.v, popExp.op, popExp.rd, popExp.res}) begin
                    fails++; $display("[TB] FAIL rand_drain: got res %0h expected %0h", obs.res, popExp.res);
                end
            end
        end
        checks++;
        if (expq.size() != 0 || out_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL rand_empty: got pending %0d v %0b expected pending 0 v 0", expq.size(), out_valid);
        end
    endtask

`ifdef ALU_RESULT_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
        flagExp = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'd1, 1'b0, 4'd1);
        tick();
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        tick();
        checks++;
        if (stat_results !== 16'd1 || stat_stalls !== 16'd0) begin
            fails++; $display("[TB] FAIL stats_count: got results %0d stalls %0d expected 1 0", stat_results, stat_stalls);
        end
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'd2, 1'b0, 4'd2);
        tick();
        drive(1'b0, 3'b000, 32'd0, 1'b0, 4'd0);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stat_stalls !== 16'hFFFF || stat_results !== 16'd1) begin
            fails++; $display("[TB] FAIL stats_saturate: got stalls %0h results %0d expected ffff 1", stat_stalls, stat_results);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_flag();
        test_backpressure();
        test_push_pop();
        test_reset_full();
        test_random();
`ifdef ALU_RESULT_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width of result.
REQ-002 SHALL have parameter: RD_WIDTH, 4, destination-register index width.
REQ-003 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  input  1  ALU result offered; in_ready  output  1  stage can accept.
REQ-006 SHALL have ports: in_op  input  3  ALU op code; in_result  input  WIDTH  ALU out; in_is_zero  input  1  ALU is_zero; in_rd  input  RD_WIDTH  destination register.
REQ-007 SHALL have ports: out_valid  output  1; out_ready  input  1; out_op  output  3; out_result  output  WIDTH; out_rd  output  RD_WIDTH (writeback side).
REQ-008 SHALL have port: flag_zero  output  1  architectural zero flag.

Function
REQ-009 SHALL implement a 2-entry in-order skid buffer between ALU and writeback; transfer occurs when valid and ready are both high on a rising edge.
REQ-010 SHALL use states EMPTY, ONE, FULL; out_valid = (state != EMPTY); in_ready = (state != FULL), both driven from registers only, no combinational path from out_ready to in_ready.
REQ-011 SHALL present an entry accepted at edge N on out_* after edge N (one-cycle latency) when the buffer was EMPTY.
REQ-012 Transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE with new entry at head; FULL+pop -> ONE with second entry promoted to head; FULL ignores in_valid.
REQ-013 SHALL hold out_* stable while out_valid && !out_ready.
REQ-014 SHALL update flag_zero with the head entry's is_zero on each output transfer whose op is ADD(000), SUB(001), AND(101) or OR(110); shifts (010, 011) and pass (100) SHALL leave flag_zero unchanged.
REQ-015 Codes 111 SHALL pass through as data and not affect flag_zero.
REQ-016 out_* SHALL be zero whenever out_valid is low.

Reset
REQ-017 On reset assertion, asynchronously: state EMPTY, out_valid 0, in_ready 1 after release, out_result/out_rd/out_op 0, flag_zero 0.
REQ-018 Reset mid-transfer SHALL discard all buffered entries; no transfer counts on the edge where reset is high.

Configuration
REQ-019 Macro ALU_RESULT_STATS_EN: when defined, SHALL add outputs stat_results (16 bits, count of output transfers) and stat_stalls (16 bits, cycles with out_valid && !out_ready), both saturating at 0xFFFF and reset to 0.
REQ-020 Without ALU_RESULT_STATS_EN the ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-021 ALU op-code encodings (000..110) and state encodings SHALL live in a shared included definitions file used also by the ALU and decoder.
REQ-022 The 2-entry storage SHALL be one sub-module, alu_skid_buffer2, parameterised on total payload width; flag and stats logic stay in the top.

Verification
REQ-023 Reset then ADD 2536+113=2649, is_zero 0, rd 3, out_ready 1 -> out_valid next cycle with out_result 2649, out_rd 3; flag_zero 0.
REQ-024 SUB result 0, is_zero 1, then LSR result 10144 is_zero 0 -> flag_zero 1 after SUB transfer, stays 1 after LSR transfer.
REQ-025 out_ready 0, push AND 96 then OR 3561 -> in_ready low after second push, third offer ignored; raise out_ready -> 96 then 3561 in order, in_ready high after first pop.
REQ-026 State ONE with simultaneous push (RSR 158) and pop -> state stays ONE, out_result 158 next cycle, no loss.
REQ-027 State FULL, assert reset asynchronously mid-cycle -> out_valid 0 and flag_zero 0 immediately; with ALU_RESULT_STATS_EN, 70000 stall cycles -> stat_stalls 0xFFFF.
